// File: rtl/ppt_multi_regmap_if.sv
// Host byte bus between the I2C slave back end and ppt_multi_regmap.
// Handshake: wr_en and rd_en are single-cycle strobes, one byte each, with no
// back-pressure. A read strobe at edge k yields data_out with rd_valid high
// for exactly the cycle after edge k. data_out then holds until the next read.
interface ppt_multi_regmap_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] address;
  logic [7:0]        data_in;
  logic              wr_en;
  logic              rd_en;
  logic [7:0]        data_out;
  logic              rd_valid;

  modport master (
    output address, data_in, wr_en, rd_en,
    input  data_out, rd_valid
  );

  modport slave (
    input  address, data_in, wr_en, rd_en,
    output data_out, rd_valid
  );
endinterface

// File: rtl/ppt_multi_regmap.sv
// Byte-wide register map for NUM_CH PPT channels: global page plus per-channel pages.
// Optional macro PPT_AUTOSTOP_EN: a rising done[n] also clears RUN[n].
module ppt_multi_regmap #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 6,
  parameter int CLKDIV_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  ppt_multi_regmap_if.slave      bus,
  output logic [CLKDIV_W-1:0]    clk_div,
  output logic [16*NUM_CH-1:0]   period,
  output logic [16*NUM_CH-1:0]   width,
  output logic [16*NUM_CH-1:0]   count,
  output logic [NUM_CH-1:0]      run_ppt,
  input  logic [16*NUM_CH-1:0]   count_done,
  input  logic [NUM_CH-1:0]      done,
  output logic                   irq
);

  // Field index within a channel page: 0 period, 1 width, 2 count.
  logic [NUM_CH-1:0][2:0][15:0] fld_q, fld_d;
  logic [NUM_CH-1:0][2:0][7:0]  hold_q, hold_d;
  logic [NUM_CH-1:0][7:0]       snap_q, snap_d;
  logic [NUM_CH-1:0][15:0]      cdone_w;

  logic [NUM_CH-1:0]   run_q, run_d;
  logic [NUM_CH-1:0]   done_st_q, done_st_d;
  logic [NUM_CH-1:0]   irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]   done_q;
  logic [NUM_CH-1:0]   done_set, done_clr;
  logic [CLKDIV_W-1:0] clk_div_q, clk_div_d;
  logic [7:0]          dout_q, dout_d, rd_data;
  logic                rv_q, rv_d;
  logic                irq_q, irq_d;

  logic [ADDR_W-4:0]   page;
  logic [2:0]          off;

  assign page    = bus.address[ADDR_W-1:3];
  assign off     = bus.address[2:0];
  assign cdone_w = count_done;

  // Read mux works on current state only, so a same-cycle write is not visible.
  always_comb begin
    rd_data = 8'h00;
    snap_d  = snap_q;
    if (page == '0) begin
      case (off)
        3'd0:    rd_data = 8'h50;
        3'd1:    rd_data = 8'(run_q);
        3'd2:    rd_data = 8'(done_st_q);
        3'd3:    rd_data = 8'(irq_en_q);
        3'd4:    rd_data = 8'(clk_div_q);
        default: rd_data = 8'h00;
      endcase
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (page == (ADDR_W-3)'(n + 1)) begin
        case (off)
          3'd0: rd_data = fld_q[n][0][7:0];
          3'd1: rd_data = fld_q[n][0][15:8];
          3'd2: rd_data = fld_q[n][1][7:0];
          3'd3: rd_data = fld_q[n][1][15:8];
          3'd4: rd_data = fld_q[n][2][7:0];
          3'd5: rd_data = fld_q[n][2][15:8];
          3'd6: begin
            rd_data = cdone_w[n][7:0];
            if (bus.rd_en) snap_d[n] = cdone_w[n][15:8];
          end
          default: rd_data = snap_q[n];
        endcase
      end
    end
  end

  always_comb begin
    run_d     = run_q;
    irq_en_d  = irq_en_q;
    clk_div_d = clk_div_q;
    fld_d     = fld_q;
    hold_d    = hold_q;
    done_clr  = '0;
    done_set  = done & ~done_q;
`ifdef PPT_AUTOSTOP_EN
    run_d     = run_q & ~done_set;
`endif
    if (bus.wr_en) begin
      if (page == '0) begin
        case (off)
          3'd1:    run_d     = bus.data_in[NUM_CH-1:0];
          3'd2:    done_clr  = bus.data_in[NUM_CH-1:0];
          3'd3:    irq_en_d  = bus.data_in[NUM_CH-1:0];
          3'd4:    clk_div_d = bus.data_in[CLKDIV_W-1:0];
          default: ;
        endcase
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (page == (ADDR_W-3)'(n + 1)) begin
          case (off)
            3'd0:    hold_d[n][0] = bus.data_in;
            3'd1:    fld_d[n][0]  = {bus.data_in, hold_q[n][0]};
            3'd2:    hold_d[n][1] = bus.data_in;
            3'd3:    fld_d[n][1]  = {bus.data_in, hold_q[n][1]};
            3'd4:    hold_d[n][2] = bus.data_in;
            3'd5:    fld_d[n][2]  = {bus.data_in, hold_q[n][2]};
            default: ;
          endcase
        end
      end
    end
    // Set beats clear when both land on the same bit in one cycle.
    done_st_d = (done_st_q & ~done_clr) | done_set;
    irq_d     = |(done_st_q & irq_en_q);
    dout_d    = bus.rd_en ? rd_data : dout_q;
    rv_d      = bus.rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= '1;
      done_st_q <= '0;
      irq_en_q  <= '0;
      clk_div_q <= CLKDIV_W'(9);
      for (int n = 0; n < NUM_CH; n++) begin
        fld_q[n][0]  <= 16'd128;
        fld_q[n][1]  <= 16'd1;
        fld_q[n][2]  <= 16'd16;
        hold_q[n][0] <= 8'h80;
        hold_q[n][1] <= 8'h01;
        hold_q[n][2] <= 8'h10;
      end
      snap_q    <= '0;
      done_q    <= '0;
      dout_q    <= 8'h00;
      rv_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      done_st_q <= done_st_d;
      irq_en_q  <= irq_en_d;
      clk_div_q <= clk_div_d;
      fld_q     <= fld_d;
      hold_q    <= hold_d;
      snap_q    <= snap_d;
      done_q    <= done;
      dout_q    <= dout_d;
      rv_q      <= rv_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign period[16*g +: 16] = fld_q[g][0];
    assign width[16*g +: 16]  = fld_q[g][1];
    assign count[16*g +: 16]  = fld_q[g][2];
  end

  assign clk_div      = clk_div_q;
  assign run_ppt      = run_q;
  assign irq          = irq_q;
  assign bus.data_out = dout_q;
  assign bus.rd_valid = rv_q;

endmodule

// File: tb/tb_ppt_multi_regmap.sv
// Randomized + directed bench for ppt_multi_regmap with an abstract register-image model.
module tb_ppt_multi_regmap;
  localparam int NUM_CH   = 4;
  localparam int ADDR_W   = 6;
  localparam int CLKDIV_W = 5;
  localparam int MASK     = (1 << NUM_CH) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [CLKDIV_W-1:0]   clk_div;
  logic [16*NUM_CH-1:0]  period, width, count;
  logic [NUM_CH-1:0]     run_ppt;
  logic [16*NUM_CH-1:0]  count_done = '0;
  logic [NUM_CH-1:0]     done = '0;
  logic                  irq;

  ppt_multi_regmap_if #(.ADDR_W(ADDR_W)) bus ();

  ppt_multi_regmap #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CLKDIV_W(CLKDIV_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clk_div(clk_div), .period(period),
    .width(width), .count(count), .run_ppt(run_ppt), .count_done(count_done),
    .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // Register image: fields[ch][0..2] = period, width, count as plain integers.
  int m_field[NUM_CH][3];
  int m_hold[NUM_CH][3];
  int m_snap[NUM_CH];
  int m_run, m_done, m_irqen, m_clkdiv, m_dprev, m_irq, m_rv;
  bit force_en = 0;
  int force_val = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_field[n][0] = 128; m_field[n][1] = 1; m_field[n][2] = 16;
      m_hold[n][0] = 128 % 256; m_hold[n][1] = 1; m_hold[n][2] = 16;
      m_snap[n] = 0;
    end
    m_run = MASK; m_done = 0; m_irqen = 0; m_clkdiv = 9;
    m_dprev = 0; m_irq = 0; m_rv = 0;
  endfunction

  function automatic int model_read(input int a);
    int ch, off;
    if (a < 8) begin
      case (a)
        0: return 'h50;
        1: return m_run;
        2: return m_done;
        3: return m_irqen;
        4: return m_clkdiv;
        default: return 0;
      endcase
    end
    ch = a / 8 - 1;
    off = a % 8;
    if (ch >= NUM_CH) return 0;
    if (off < 6) return (m_field[ch][off / 2] >> (8 * (off % 2))) % 256;
    if (off == 6) return int'(count_done[16*ch +: 8]);
    return m_snap[ch];
  endfunction

  function automatic void model_write(input int a, input int d);
    int ch, off;
    if (a < 8) begin
      if (a == 1) m_run = d & MASK;
      if (a == 3) m_irqen = d & MASK;
      if (a == 4) m_clkdiv = d % (1 << CLKDIV_W);
      return;
    end
    ch = a / 8 - 1;
    off = a % 8;
    if (ch >= NUM_CH || off >= 6) return;
    if (off % 2 == 0) m_hold[ch][off / 2] = d;
    else m_field[ch][off / 2] = d * 256 + m_hold[ch][off / 2];
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    int a, d, rise, clr, irq_n, v;
    if (rst) begin
      model_reset();
      return;
    end
    a = int'(bus.address);
    d = int'(bus.data_in);
    rise = int'(done) & ~m_dprev & MASK;
    irq_n = ((m_done & m_irqen) != 0) ? 1 : 0;
    if (bus.rd_en) begin
      v = model_read(a);
      if (force_en) v = force_val;
      exp_q.push_back(8'(v));
      if (a >= 8 && a % 8 == 6 && a / 8 - 1 < NUM_CH)
        m_snap[a / 8 - 1] = int'(count_done[16*(a/8-1) + 8 +: 8]);
    end
    m_rv = bus.rd_en ? 1 : 0;
    clr = (bus.wr_en && a == 2) ? (d & MASK) : 0;
`ifdef PPT_AUTOSTOP_EN
    m_run = m_run & ~rise;
`endif
    if (bus.wr_en) model_write(a, d);
    m_done = (m_done & ~clr) | rise;
    m_dprev = int'(done);
    m_irq = irq_n;
  endfunction

  task automatic drive(input logic r, input logic w, input logic rd, input int a, input int d);
    rst = r;
    bus.wr_en = w;
    bus.rd_en = rd;
    bus.address = ADDR_W'(a);
    bus.data_in = 8'(d);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic read_expect(input int a, input int v);
    force_en = 1;
    force_val = v;
    drive(0, 0, 1, a, 0);
    force_en = 0;
  endtask

  task automatic wr(input int a, input int d);
    drive(0, 1, 0, a, d);
  endtask

  // Monitor: pops expected read data on rd_valid and checks live outputs.
  always @(negedge clk) begin
    logic [16*NUM_CH-1:0] ep, ew, ec;
    for (int n = 0; n < NUM_CH; n++) begin
      ep[16*n +: 16] = 16'(m_field[n][0]);
      ew[16*n +: 16] = 16'(m_field[n][1]);
      ec[16*n +: 16] = 16'(m_field[n][2]);
    end
    check("rd_valid", 64'(bus.rd_valid), 64'(m_rv));
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_read", 64'(bus.data_out), 64'hFFFF);
      else check("data_out", 64'(bus.data_out), 64'(exp_q.pop_front()));
    end
    check("period", 64'(period), 64'(ep));
    check("width", 64'(width), 64'(ew));
    check("count", 64'(count), 64'(ec));
    check("run_ppt", 64'(run_ppt), 64'(m_run));
    check("clk_div", 64'(clk_div), 64'(m_clkdiv));
    check("irq", 64'(irq), 64'(m_irq));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int op, a, d;
    bus.address = '0; bus.data_in = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    read_expect('h04, 'h09);
    read_expect('h08, 'h80);
    read_expect('h0A, 'h01);
    read_expect('h0C, 'h10);
    read_expect('h01, 'h0F);
    read_expect('h00, 'h50);

    wr('h10, 'h34);
    check("period1_before_commit", 64'(period[31:16]), 64'h0080);
    read_expect('h10, 'h80);
    wr('h11, 'h12);
    check("period1_after_commit", 64'(period[31:16]), 64'h1234);
    wr('h13, 'h00);
    check("width1_reuse_hold", 64'(width[31:16]), 64'h0001);

    count_done[15:0] = 16'h01FF;
    read_expect('h0E, 'hFF);
    count_done[15:0] = 16'h0200;
    read_expect('h0F, 'h01);

    wr('h03, 'h04);
    done = 4'b0100;
    drive(0, 0, 0, 0, 0);
    read_expect('h02, 'h04);
    check("irq_set", 64'(irq), 64'h1);
    done = 4'b0000;
    drive(0, 0, 0, 0, 0);
    done = 4'b0100;
    wr('h02, 'h04);
    read_expect('h02, 'h04);
    wr('h02, 'h04);
    drive(0, 0, 0, 0, 0);
    check("irq_cleared", 64'(irq), 64'h0);
    read_expect('h02, 'h00);

    wr('h3F, 'hAA);
    wr('h05, 'hAA);
    wr('h38, 'h55);
    wr('h39, 'h66);
    read_expect('h3F, 'h00);
    read_expect('h05, 'h00);
    read_expect('h39, 'h00);

    drive(0, 1, 1, 'h03, 'h0B);
    read_expect('h03, 'h0B);

    wr('h01, 'h0F);
    done = 4'b0101;
    drive(0, 0, 0, 0, 0);
`ifdef PPT_AUTOSTOP_EN
    check("autostop_run", 64'(run_ppt), 64'h0E);
`else
    check("autostop_run", 64'(run_ppt), 64'h0F);
`endif

    wr('h20, 'h55);
    done = 4'b0000;
    drive(0, 0, 0, 0, 0);
    done = 4'b0001;
    drive(1, 0, 0, 0, 0);
    done = 4'b0000;
    wr('h21, 'h00);
    check("hold_reset", 64'(period[63:48]), 64'h0080);
    read_expect('h02, 'h00);

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 3);
      a = $urandom_range(0, 63);
      d = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) done = NUM_CH'($urandom);
      if ($urandom_range(0, 7) == 0) count_done = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) drive(1, 0, 0, 0, 0);
      else drive(0, op[0], op[1], a, d);
    end

    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("exp_q_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ppt_multi_regmap.md
Name: ppt_multi_regmap

Overview:
Byte-wide register map serving NUM_CH independent PPT pulse-controller channels from a single host bus (I2C slave back end).
- Shared global page: ID, run mask, sticky done/IRQ, clock divider.
- Per-channel pages: period, width, count and count-done.
- New over the single-channel map: atomic 16-bit updates via holding bytes, coherent 16-bit status reads, W1C sticky done flags, interrupt output, registered read path.

Parameters:
NUM_CH, 4, number of PPT channels (1..7)
ADDR_W, 6, host address width (must be ≥ 6)
CLKDIV_W, 5, width of shared clock-divider field

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
address  in  ADDR_W  host register address
data_in  in  8  host write data
wr_en  in  1  host write strobe, one cycle per byte
rd_en  in  1  host read strobe, one cycle per byte
data_out  out  8  registered read data
rd_valid  out  1  high one cycle after rd_en
clk_div  out  CLKDIV_W  shared PPT clock divider
period  out  16*NUM_CH  per-channel period, channel n at [16n+15:16n]
width  out  16*NUM_CH  per-channel pulse width
count  out  16*NUM_CH  per-channel firing count
run_ppt  out  NUM_CH  per-channel run enable
count_done  in  16*NUM_CH  per-channel firings completed
done  in  NUM_CH  per-channel done level from controllers
irq  out  1  interrupt, level

Behaviour:
- Address map, global page:
  - 0x00 ID, RO, constant 0x50.
  - 0x01 RUN, RW, bits[NUM_CH-1:0].
  - 0x02 DONE, sticky, W1C.
  - 0x03 IRQ_EN, RW.
  - 0x04 CLK_DIV, RW, low CLKDIV_W bits.
  - 0x05–0x07 reserved.
- Address map, channel n page (base 8*(n+1)):
  - +0 PERIOD_L, +1 PERIOD_H, +2 WIDTH_L, +3 WIDTH_H, +4 COUNT_L, +5 COUNT_H.
  - +6 CDONE_L, RO; +7 CDONE_H, RO.
- Unmapped addresses, reserved addresses and channels ≥ NUM_CH: read 0x00, writes ignored. RO writes ignored. Unused upper bits of narrow registers read 0.
- Reset values (rst high at posedge):
  - clk_div=9; each period=128, width=1, count=16.
  - run_ppt = all ones (fallback when host is dead).
  - IRQ_EN=0, DONE=0, data_out=0x00, rd_valid=0, irq=0.
  - Holding bytes = low bytes of the defaults; snapshots=0; done_q=0.
- Atomic 16-bit writes:
  - Writing *_L updates only that field's holding byte; the live output is unchanged.
  - Writing *_H commits {data_in, hold} to the live output on the same edge, visible the next cycle.
  - H write without a preceding L write reuses the current hold value.
  - Reading *_L returns the live low byte, not the hold byte.
- Reads:
  - rd_en at edge k → data_out/rd_valid valid after edge k; data_out holds its value until the next rd_en.
  - wr_en and rd_en together on the same address: read returns the pre-write value.
- Coherent status read:
  - A read of CDONE_L(n) returns count_done[n][7:0] and, on the same edge, latches count_done[n][15:8] into snap_h[n].
  - A read of CDONE_H(n) returns snap_h[n].
- Sticky done:
  - done_q registers done every cycle. A rising edge on done[n] (done & ~done_q) sets DONE[n].
  - A write to 0x02 clears the DONE bits where data_in=1.
  - Set and clear in the same cycle: set wins.
- irq = |(DONE & IRQ_EN), registered (one cycle after the DONE/IRQ_EN update).
- Reset mid-operation: all state returns to reset values, including pending holding bytes; a rising done edge coincident with rst is lost.

Optional Feature:
Macro PPT_AUTOSTOP_EN.
- Defined: the rising edge of done[n] also clears RUN[n] on the same edge. A host write to RUN in that same cycle takes precedence for that bit.
- Undefined: RUN changes only by host write; done has no effect on run_ppt.

Test Plan:
- Reset → read 0x04=0x09, 0x08=0x80, 0x0A=0x01, 0x0C=0x10, 0x01=0x0F, 0x00=0x50; each with rd_valid one cycle after rd_en.
- Write 0x10=0x34 → period[31:16] still 0x0080; write 0x11=0x12 → next cycle period[31:16]=0x1234.
- count_done[15:0]=0x01FF, read 0x0E → 0xFF; change count_done to 0x0200, read 0x0F → 0x01 (snapshot, not 0x02).
- done[2] rises, IRQ_EN=0x04 → DONE=0x04, irq=1; write 0x02=0x04 on the same cycle a new done[2] edge occurs → DONE stays 0x04; clear with no edge → DONE=0, irq=0 the following cycle.
- Write 0x3F and 0x05 with NUM_CH=4 → no state change; reads return 0x00.
- PPT_AUTOSTOP_EN defined, RUN=0x0F, done[0] rises → run_ppt=0x0E; undefined → run_ppt stays 0x0F.
